// File: rtl/my_module_if.sv
// my_if: bench-side bundle of the frame sync block pins.
// Ports: clk, reset_n (sync, high = reset), data_in, data_out.
interface my_if;
   logic clk;
   logic reset_n;
   logic data_in;
   logic data_out;
endinterface

// File: rtl/my_module.sv
// my_module: serial frame sync with flywheel lock and even parity.
// Ports: clk, reset_n (sync, 1 = reset), data_in (serial), data_out (good pulse).
module my_module #(
   parameter logic [7:0] SYNC_WORD   = 8'hA5,
   parameter int         PAYLOAD_LEN = 8,
   parameter int         MAX_MISS    = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic data_in,
   output logic data_out
);

   typedef enum logic [1:0] {
      HUNT,
      PAYLOAD,
      PARITY,
      VERIFY
   } state_t;

   localparam logic [6:0] LAST_PAY = 7'(PAYLOAD_LEN - 1);
   localparam logic [3:0] MISS_LIM = 4'(MAX_MISS);

   state_t     state;
   state_t     state_nx;
   logic [7:0] sr;
   logic [6:0] bit_cnt;
   logic [6:0] bit_cnt_nx;
   logic       par_acc;
   logic       par_nx;
   logic [3:0] miss;
   logic [3:0] miss_nx;
   logic [3:0] miss_inc;
   logic       pulse_nx;
   logic       sync_hit;
   logic       parity_ok;

   // sr shifts in every state so it always holds the last 8 bits;
   // this doubles as the VERIFY collector and keeps history across
   // a loss of lock.
   assign sync_hit  = ({sr[6:0], data_in} == SYNC_WORD);
   assign parity_ok = ~(par_acc ^ data_in);
   assign miss_inc  = miss + 4'd1;

   always_ff @(posedge clk) begin
      if (reset_n) begin
         state    <= HUNT;
         sr       <= '0;
         bit_cnt  <= '0;
         par_acc  <= 1'b0;
         miss     <= '0;
         data_out <= 1'b0;
      end else begin
         state    <= state_nx;
         sr       <= {sr[6:0], data_in};
         bit_cnt  <= bit_cnt_nx;
         par_acc  <= par_nx;
         miss     <= miss_nx;
         data_out <= pulse_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      par_nx     = par_acc;
      miss_nx    = miss;
      unique case (state)
         HUNT: begin
            if (sync_hit) begin
               state_nx   = PAYLOAD;
               bit_cnt_nx = '0;
               par_nx     = 1'b0;
               miss_nx    = '0;
            end
         end
         PAYLOAD: begin
            par_nx = par_acc ^ data_in;
            if (bit_cnt == LAST_PAY) begin
               state_nx   = PARITY;
               bit_cnt_nx = '0;
            end else begin
               bit_cnt_nx = bit_cnt + 7'd1;
            end
         end
         PARITY: begin
            bit_cnt_nx = '0;
            par_nx     = 1'b0;
            if (parity_ok) begin
               miss_nx  = '0;
               state_nx = VERIFY;
            end else if (miss_inc == MISS_LIM) begin
               miss_nx  = '0;
               state_nx = HUNT;
            end else begin
               miss_nx  = miss_inc;
               state_nx = VERIFY;
            end
         end
         VERIFY: begin
            if (bit_cnt == 7'd7) begin
               bit_cnt_nx = '0;
               par_nx     = 1'b0;
               if (sync_hit) begin
                  state_nx = PAYLOAD;
               end else if (miss_inc == MISS_LIM) begin
                  miss_nx  = '0;
                  state_nx = HUNT;
               end else begin
                  // flywheel: keep frame position despite bad sync
                  miss_nx  = miss_inc;
                  state_nx = PAYLOAD;
               end
            end else begin
               bit_cnt_nx = bit_cnt + 7'd1;
            end
         end
      endcase
   end

   always_comb begin
      pulse_nx = 1'b0;
      if (state == PARITY) begin
         pulse_nx = parity_ok;
      end
   end

endmodule

// File: tb/tb_my_module.sv
// tb_my_module: per-cycle vector table check of my_module.
// Drives reset_n/data_in each cycle, compares data_out after each edge.
module tb_my_module;

  typedef struct {
    logic  rst;
    logic  din;
    logic  exp;
    string tag;
  } vec_t;

  my_if bus ();

  my_module dut (
    .clk      (bus.clk),
    .reset_n  (bus.reset_n),
    .data_in  (bus.data_in),
    .data_out (bus.data_out)
  );

  vec_t        vecs[$];
  int          n_pass;
  int          n_total;
  logic [16:0] fr;
  logic        got;

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  task automatic add(input logic r, input logic d,
                     input logic e, input string t);
    vec_t v;
    v.rst = r;
    v.din = d;
    v.exp = e;
    v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic add_bits(input logic [7:0] b, input int n,
                          input string t);
    for (int i = n - 1; i >= 0; i--)
      add(1'b0, b[i], 1'b0, t);
  endtask

  task automatic add_frame(input logic [7:0] s,
                           input logic [7:0] p,
                           input logic par, input logic pulse,
                           input string t);
    add_bits(s, 8, t);
    add_bits(p, 8, t);
    add(1'b0, par, pulse, t);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    for (int i = 0; i < 5; i++)
      add(1'b1, 1'(i & 1), 1'b0, "rst_hold");
    for (int i = 0; i < 20; i++)
      add(1'b0, 1'b0, 1'b0, "idle");

    add_bits(8'hA5 >> 1, 7, "rst_vs_sync");
    add(1'b1, 1'b1, 1'b0, "rst_vs_sync");
    add_bits(8'h00, 4, "rst_vs_sync");

    add_frame(8'hA5, 8'h3C, 1'b0, 1'b1, "good_3c");
    add_frame(8'hA5, 8'h3C, 1'b1, 1'b0, "bad_par");
    add_frame(8'hA5, 8'h01, 1'b1, 1'b1, "good_01");

    add_frame(8'hA5, 8'h55, 1'b0, 1'b1, "good_55");
    add_frame(8'hA4, 8'h3C, 1'b0, 1'b1, "flywheel");
    add_frame(8'hA5, 8'h3C, 1'b0, 1'b1, "after_fly");
    add_frame(8'hA5, 8'h01, 1'b1, 1'b1, "after_fly2");

    add_frame(8'h00, 8'h00, 1'b1, 1'b0, "lose_1");
    add_frame(8'h00, 8'h00, 1'b1, 1'b0, "lose_2");
    add_frame(8'h00, 8'h00, 1'b1, 1'b0, "lose_3");
    add_bits(8'h16, 5, "junk");
    add_frame(8'hA5, 8'h3C, 1'b0, 1'b1, "relock");

    add_frame(8'hA5, 8'h3C, 1'b1, 1'b0, "pmiss_1");
    add_frame(8'hA5, 8'h3C, 1'b1, 1'b0, "pmiss_2");
    add_frame(8'hA5, 8'h3C, 1'b1, 1'b0, "pmiss_3");
    add_frame(8'hA5, 8'h01, 1'b1, 1'b1, "immed_sync");

    add_bits(8'hA5, 8, "mid_rst");
    add_bits(8'h03, 4, "mid_rst");
    add(1'b1, 1'b1, 1'b0, "mid_rst");
    add_bits(8'h0C, 4, "mid_rst");
    add(1'b0, 1'b0, 1'b0, "mid_rst");
    add_frame(8'hA5, 8'h3C, 1'b0, 1'b1, "post_rst");
    add_bits(8'h00, 4, "tail");

    bus.reset_n = 1'b1;
    bus.data_in = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.reset_n = vecs[i].rst;
      bus.data_in = vecs[i].din;
      @(posedge bus.clk);
      #1;
      n_total++;
      if (bus.data_out === vecs[i].exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s[%0d]: data_out=%0b expected %0b",
                 vecs[i].tag, i, bus.data_out, vecs[i].exp);
      end
    end

    bus.reset_n = 1'b1;
    bus.data_in = 1'b1;
    repeat (2) begin
      @(posedge bus.clk);
      #1;
    end
    n_total++;
    if (bus.data_out === 1'b0) begin
      n_pass++;
    end else begin
      $display("FAIL reset_state: data_out=%0b expected 0",
               bus.data_out);
    end

    bus.reset_n = 1'b0;
    fr = {8'hA5, 8'h3C, 1'b0};
    for (int i = 16; i >= 0; i--) begin
      bus.data_in = fr[i];
      @(posedge bus.clk);
      #1;
    end
    got = 1'b0;
    bus.data_in = 1'b0;
    for (int w = 0; w < 4 && !got; w++) begin
      if (bus.data_out === 1'b1) begin
        got = 1'b1;
      end else begin
        @(posedge bus.clk);
        #1;
      end
    end
    n_total++;
    if (got) begin
      n_pass++;
    end else begin
      $display("FAIL wait_pulse: wait expired, no pulse");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
